// File: rtl/data_mem_responder.sv
// Data-memory responder: word storage with byte-lane writes, LATENCY wait states and a one-cycle response.
// Define DMEM_BACK2BACK_EN to let the RESP cycle accept the next request (back-to-back responses).
module data_mem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_we,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  LAT     = 4'(LATENCY);
    localparam logic [29:0] DEPTH_W = 30'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [29:0] word_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic [3:0]  be_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;

    logic [31:0] mem [DEPTH];

    logic          accept;
    logic          direct;
    logic          acc_fire;
    logic          acc_ok;
    logic          be_legal;
    logic          acc_we;
    logic [29:0]   acc_word;
    logic [31:0]   acc_wdata;
    logic [3:0]    acc_be;
    logic [AW-1:0] acc_idx;
    logic [31:0]   lane_mask;
    logic [31:0]   rd_word;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^req_addr[1:0];

`ifdef DMEM_BACK2BACK_EN
    assign req_ready = (state_q == IDLE) || (state_q == RESP);
`else
    assign req_ready = (state_q == IDLE);
`endif

    assign accept = req_valid && req_ready;

    // With zero wait states the access happens on the acceptance edge, so it uses the live request fields.
    assign direct   = accept && (LAT == 4'd0);
    assign acc_fire = direct || ((state_q == WAIT) && (cnt_q == 4'd1));

    assign acc_word  = direct ? req_addr[31:2] : word_q;
    assign acc_wdata = direct ? req_wdata      : wdata_q;
    assign acc_we    = direct ? req_we         : we_q;
    assign acc_be    = direct ? req_be         : be_q;
    assign acc_idx   = acc_word[AW-1:0];

    always_comb begin
        be_legal = 1'b0;
        case (acc_be)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: be_legal = 1'b1;
            default:                   be_legal = 1'b0;
        endcase
    end

    assign acc_ok    = be_legal && (acc_word < DEPTH_W);
    assign lane_mask = {{8{acc_be[3]}}, {8{acc_be[2]}}, {8{acc_be[1]}}, {8{acc_be[0]}}};
    assign rd_word   = mem[acc_idx] & lane_mask;

    // Storage has no reset; a reset at the access edge suppresses the write.
    always_ff @(posedge clk) begin
        if (acc_fire && acc_ok && acc_we && !reset) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_be[b]) begin
                    mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            word_q       <= 30'd0;
            wdata_q      <= 32'd0;
            we_q         <= 1'b0;
            be_q         <= 4'd0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            if (acc_fire) begin
                resp_valid_q <= 1'b1;
                resp_err_q   <= !acc_ok;
                resp_rdata_q <= (acc_ok && !acc_we) ? rd_word : 32'd0;
            end

            case (state_q)
                IDLE, RESP: begin
                    if (accept) begin
                        word_q  <= req_addr[31:2];
                        wdata_q <= req_wdata;
                        we_q    <= req_we;
                        be_q    <= req_be;
                        cnt_q   <= LAT;
                        state_q <= (LAT == 4'd0) ? RESP : WAIT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                WAIT: begin
                    cnt_q <= 4'(cnt_q - 4'd1);
                    if (cnt_q == 4'd1) begin
                        state_q <= RESP;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign busy       = (state_q != IDLE);

endmodule
